// File: rtl/bus_trace_pkg.sv
// Shared types and constants for the bus trace buffer: capture states,
// trigger-mode encodings and the packed trace-entry width.
package bus_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

  localparam logic [1:0] TRIG_ANY_WR  = 2'b00;
  localparam logic [1:0] TRIG_ADDR    = 2'b01;
  localparam logic [1:0] TRIG_ADDR_WR = 2'b10;
  localparam logic [1:0] TRIG_NOW     = 2'b11;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  // One trace entry is {wr_en, addr, data}.
  function automatic int entry_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/trace_mem.sv
// Simple dual-port trace RAM: one write port and one registered read port.
module trace_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 25
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the storage array is deliberately left without reset so it can map
  // onto RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/bus_trace_buffer.sv
// Passive logic-analyser tap on the CPU/RAM/ROM bus: circular capture with a
// programmable trigger and post-trigger count, indexed readback once frozen.
module bus_trace_buffer
  import bus_trace_pkg::*;
#(
  parameter int  ADDR_W = ADDR_W_DEF,
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  localparam int PW     = $clog2(DEPTH),
  localparam int EW     = entry_width(ADDR_W, DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [1:0]        trig_mode,
  input  logic [ADDR_W-1:0] trig_addr,
  input  logic [ADDR_W-1:0] trig_mask,
  input  logic [PW-1:0]     post_cnt,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic [DATA_W-1:0] data_bus,
  input  logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic [PW:0]       count,
  output logic [PW-1:0]     trig_idx,
  input  logic              rd_en,
  input  logic [PW-1:0]     rd_idx,
  output logic              rd_valid,
  output logic [EW-1:0]     rd_data
);

  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] REM_MAX = PW'(DEPTH - 1);

  trace_state_t  state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rem_q, rem_d;
  logic [PW-1:0] trig_ptr_q, trig_ptr_d;
  logic [PW-1:0] trig_idx_q, trig_idx_d;
  logic [PW:0]   count_q, count_d;
  logic          rd_valid_q, rd_zero_q;

  logic          addr_match, trig_hit, mem_we, finish, rd_accept;
  logic [PW:0]   count_inc;
  logic [PW-1:0] rem_load, rd_phys;
  logic [EW-1:0] sample, mem_rdata;

  assign sample = {wr_en, addr_bus, data_bus};

  // Trigger compare on the live bus sample.
  always_comb begin
    addr_match = ((addr_bus ^ trig_addr) & trig_mask) == '0;
    trig_hit   = 1'b0;
    unique case (trig_mode)
      TRIG_ANY_WR:  trig_hit = wr_en;
      TRIG_ADDR:    trig_hit = addr_match;
      TRIG_ADDR_WR: trig_hit = addr_match & wr_en;
      TRIG_NOW:     trig_hit = 1'b1;
      default:      trig_hit = 1'b0;
    endcase
  end

  // Clamping below DEPTH keeps the trigger sample from being overwritten by
  // post-trigger samples should post_cnt ever be widened.
  assign rem_load  = (post_cnt > REM_MAX) ? REM_MAX : post_cnt;
  assign count_inc = (count_q == DEPTH_C) ? count_q : count_q + 1'b1;

  // NOTE: every combinational output gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    rem_d      = rem_q;
    trig_ptr_d = trig_ptr_q;
    trig_idx_d = trig_idx_q;
    mem_we     = 1'b0;
    finish     = 1'b0;

    if (arm) begin
      state_d  = ARMED;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case (state_q)
        ARMED: begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_inc;
          if (trig_hit) begin
            trig_ptr_d = wr_ptr_q;
            rem_d      = rem_load;
            if (rem_load == '0) begin
              state_d = DONE;
              finish  = 1'b1;
            end else begin
              state_d = POST;
            end
          end
        end
        POST: begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_inc;
          rem_d    = rem_q - 1'b1;
          if (rem_q == PW'(1)) begin
            state_d = DONE;
            finish  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Until the buffer wraps, physical address equals oldest-first index.
    if (finish) begin
      trig_idx_d = (count_d == DEPTH_C) ? trig_ptr_d - wr_ptr_d : trig_ptr_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rem_q      <= '0;
      trig_ptr_q <= '0;
      trig_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      trig_ptr_q <= trig_ptr_d;
      trig_idx_q <= trig_idx_d;
    end
  end

  assign rd_accept = rd_en && (state_q == DONE);
  assign rd_phys   = (count_q < DEPTH_C) ? rd_idx : wr_ptr_q + rd_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) rd_zero_q <= ({1'b0, rd_idx} >= count_q);
    end
  end

  trace_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (sample),
    .re_i    (rd_accept),
    .raddr_i (rd_phys),
    .rdata_o (mem_rdata)
  );

  assign busy     = (state_q == ARMED) || (state_q == POST);
  assign done     = (state_q == DONE);
  assign count    = count_q;
  assign trig_idx = trig_idx_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_zero_q ? '0 : mem_rdata;

endmodule

// File: tb/tb_bus_trace_buffer.sv
// Directed self-checking bench for bus_trace_buffer: table of capture
// scenarios plus hand-written reset, abort and re-arm sequences.
module tb_bus_trace_buffer;
  import bus_trace_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int PW = 4;
  localparam int EW = 1 + AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm, wr_en, rd_en;
  logic [1:0]    trig_mode;
  logic [AW-1:0] trig_addr, trig_mask, addr_bus;
  logic [DW-1:0] data_bus;
  logic [PW-1:0] post_cnt, rd_idx, trig_idx;
  logic          busy, done, rd_valid;
  logic [PW:0]   count;
  logic [EW-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] trace_log [0:255];
  int            n_log;
  logic [EW-1:0] trig_sample;
  logic [EW-1:0] last_rd;

  typedef struct {
    string         name;
    logic [1:0]    mode;
    logic [AW-1:0] taddr;
    logic [AW-1:0] tmask;
    int            pre;
    logic [PW-1:0] post;
    int            exp_count;
    int            exp_tidx;
  } vec_t;

  vec_t vecs [6];

  bus_trace_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .trig_mode (trig_mode),
    .trig_addr (trig_addr),
    .trig_mask (trig_mask),
    .post_cnt  (post_cnt),
    .addr_bus  (addr_bus),
    .data_bus  (data_bus),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .trig_idx  (trig_idx),
    .rd_en     (rd_en),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    addr_bus = AW'($urandom);
    data_bus = DW'($urandom);
    wr_en    = 1'($urandom);
  endtask

  function automatic logic [AW-1:0] miss_addr(input vec_t v);
    logic [AW-1:0] a, low;
    a   = AW'($urandom);
    low = v.tmask & (~v.tmask + 1'b1);
    return (a & ~v.tmask) | ((v.taddr & v.tmask) ^ low);
  endfunction

  function automatic logic [AW-1:0] hit_addr(input vec_t v);
    logic [AW-1:0] a;
    a = AW'($urandom);
    return (a & ~v.tmask) | (v.taddr & v.tmask);
  endfunction

  // A sample that must not fire the trigger in the vector's mode.
  task automatic drive_pre(input vec_t v, input int i);
    data_bus = DW'($urandom);
    case (v.mode)
      TRIG_ANY_WR: begin addr_bus = AW'($urandom); wr_en = 1'b0; end
      TRIG_ADDR:   begin addr_bus = miss_addr(v);  wr_en = 1'($urandom); end
      default: begin
        if (i % 2 == 0) begin addr_bus = hit_addr(v);  wr_en = 1'b0; end
        else            begin addr_bus = miss_addr(v); wr_en = 1'b1; end
      end
    endcase
  endtask

  task automatic drive_trig(input vec_t v);
    data_bus = DW'($urandom);
    wr_en    = 1'b1;
    addr_bus = (v.mode == TRIG_ANY_WR || v.mode == TRIG_NOW) ? AW'($urandom) : hit_addr(v);
  endtask

  task automatic log_now();
    trace_log[n_log] = {wr_en, addr_bus, data_bus};
    n_log++;
  endtask

  function automatic logic [EW-1:0] exp_entry(input int k, input int c);
    if (k < c) return trace_log[n_log - c + k];
    return '0;
  endfunction

  task automatic read_one(input string nm, input int idx, input logic [EW-1:0] exp);
    rd_en  = 1'b1;
    rd_idx = PW'(idx);
    step();
    rd_en  = 1'b0;
    check({nm, " rd_valid"}, rd_valid, 1);
    check({nm, " rd_data"}, rd_data, exp);
    last_rd = exp;
  endtask

  task automatic read_pair(input string nm, input int i0, input logic [EW-1:0] e0,
                           input int i1, input logic [EW-1:0] e1);
    rd_en  = 1'b1;
    rd_idx = PW'(i0);
    step();
    check({nm, " b2b0 valid"}, rd_valid, 1);
    check({nm, " b2b0 data"}, rd_data, e0);
    rd_idx = PW'(i1);
    step();
    rd_en  = 1'b0;
    check({nm, " b2b1 valid"}, rd_valid, 1);
    check({nm, " b2b1 data"}, rd_data, e1);
    last_rd = e1;
  endtask

  task automatic run_capture(input vec_t v);
    int guard;
    trig_mode = v.mode;
    trig_addr = v.taddr;
    trig_mask = v.tmask;
    post_cnt  = v.post;
    arm = 1'b1;
    drive_random();
    step();
    arm = 1'b0;
    check({v.name, " armed busy"}, busy, 1);
    check({v.name, " armed count"}, count, 0);
    check({v.name, " armed done"}, done, 0);
    n_log = 0;
    for (int i = 0; i < v.pre; i++) begin
      drive_pre(v, i);
      log_now();
      step();
    end
    check({v.name, " no early trigger"}, {busy, done}, 2'b10);
    drive_trig(v);
    trig_sample = {wr_en, addr_bus, data_bus};
    log_now();
    step();
    guard = 0;
    while (!done && guard < 64) begin
      drive_random();
      log_now();
      step();
      guard++;
    end
    check({v.name, " done reached"}, done, 1);
    check({v.name, " busy after done"}, busy, 0);
    check({v.name, " samples stored"}, n_log, v.pre + 1 + int'(v.post));
  endtask

  initial begin
    vecs[0] = '{"anywr",  TRIG_ANY_WR,  16'h0000, 16'h0000, 5,  4'd2,  8,  5};
    vecs[1] = '{"addr",   TRIG_ADDR,    16'h0010, 16'hFFFF, 40, 4'd3,  16, 12};
    vecs[2] = '{"clamp",  TRIG_ADDR,    16'h0010, 16'hFFFF, 20, 4'd15, 16, 0};
    vecs[3] = '{"now",    TRIG_NOW,     16'h0000, 16'h0000, 0,  4'd0,  1,  0};
    vecs[4] = '{"addrwr", TRIG_ADDR_WR, 16'h1234, 16'hFFFF, 6,  4'd4,  11, 6};
    vecs[5] = '{"masked", TRIG_ADDR,    16'h0030, 16'h00F0, 3,  4'd1,  5,  3};

    rst = 1'b0; arm = 1'b0; rd_en = 1'b0; rd_idx = '0;
    trig_mode = '0; trig_addr = '0; trig_mask = '0; post_cnt = '0;
    last_rd = '0;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      step();
    end
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset count", count, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset trig_idx", trig_idx, 0);
    check("reset rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b1;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("idle read ignored", rd_valid, 0);

    for (int vi = 0; vi < 6; vi++) begin
      vec_t v;
      int c;
      v = vecs[vi];
      c = v.exp_count;
      run_capture(v);
      check({v.name, " count"}, count, c);
      check({v.name, " trig_idx"}, trig_idx, v.exp_tidx);
      read_one({v.name, " trigger entry"}, v.exp_tidx, trig_sample);
      read_pair(v.name, 0, exp_entry(0, c), c - 1, exp_entry(c - 1, c));
      if (c < DEPTH) read_one({v.name, " beyond count"}, c, '0);
    end

    // Abort mid-POST: reads ignored while busy, then async reset.
    trig_mode = TRIG_NOW;
    post_cnt  = 4'd10;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      step();
    end
    check("post busy", busy, 1);
    rd_en  = 1'b1;
    rd_idx = '0;
    step();
    rd_en  = 1'b0;
    check("busy read rd_valid", rd_valid, 0);
    check("busy read rd_data held", rd_data, last_rd);
    #2;
    rst = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort count", count, 0);
    @(negedge clk);
    rst = 1'b1;

    // Re-arm while DONE restarts the capture from an empty buffer.
    run_capture(vecs[3]);
    check("pre-rearm count", count, 1);
    trig_mode = TRIG_ANY_WR;
    wr_en = 1'b0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("rearm done", done, 0);
    check("rearm count", count, 0);
    check("rearm busy", busy, 1);
    step();
    check("rearm count after sample", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
